// File: rtl/dncntr_pkg.sv
// Shared FSM encoding and constant helpers for the down counter.
package dncntr_pkg;

    localparam int unsigned MAX_WIDTH = 16;

    typedef enum logic {
        RUN = 1'b0,
        SAT = 1'b1
    } fsm_t;

    // All-ones value of a w-bit counter; usable in constant expressions.
    function automatic logic [MAX_WIDTH-1:0] all_ones(input int unsigned w);
        all_ones = MAX_WIDTH'((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/trig_edge_det.sv
// 1-bit rising-edge detector with registered pulse output and synchronous reset.
module trig_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic prev;

    // prev resets high so a level already asserted at reset release is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= 1'b1;
            rise <= 1'b0;
        end else begin
            prev <= din;
            rise <= din & ~prev;
        end
    end

endmodule

// File: rtl/dncntr_fsm.sv
// Down counter FSM (RUN/SAT) with zero, underflow and saturation status.
// Define DNCNTR_TRIG_EDGE_EN for edge-qualified trigger (one extra cycle latency).
module dncntr_fsm
    import dncntr_pkg::*;
#(
    parameter int unsigned       WIDTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             trigger,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             wrap_en,
    output logic [WIDTH-1:0] state,
    output logic             zero,
    output logic             underflow,
    output logic             saturated
);

    localparam logic [WIDTH-1:0] ONES = WIDTH'(all_ones(WIDTH));

    logic count_en;
    fsm_t fsm;

`ifdef DNCNTR_TRIG_EDGE_EN
    trig_edge_det u_trig_edge_det (
        .clk   (clk),
        .reset (reset),
        .din   (trigger),
        .rise  (count_en)
    );
`else
    assign count_en = trigger;
`endif

    // Priority per edge: reset > load > count
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= RUN;
            state     <= RESET_VAL;
            zero      <= (RESET_VAL == '0);
            underflow <= 1'b0;
            saturated <= 1'b0;
        end else begin
            underflow <= 1'b0;
            if (load) begin
                fsm       <= RUN;
                state     <= load_val;
                zero      <= (load_val == '0);
                saturated <= 1'b0;
            end else begin
                case (fsm)
                    RUN: begin
                        if (count_en) begin
                            if (state != '0) begin
                                state <= state - WIDTH'(1);
                                zero  <= (state == WIDTH'(1));
                            end else if (wrap_en) begin
                                state     <= ONES;
                                zero      <= 1'b0;
                                underflow <= 1'b1;
                            end else begin
                                fsm       <= SAT;
                                saturated <= 1'b1;
                            end
                        end
                    end
                    SAT: begin
                        state     <= '0;
                        zero      <= 1'b1;
                        saturated <= 1'b1;
                    end
                    default: begin
                        fsm <= RUN;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/dncntr_fsm.md
Name: dncntr_fsm

Overview:
- Synchronous down counter FSM; the counterpart of the team's 2-bit up counter (`upcntr`).
- Counts from a loaded or reset value toward zero, one step per qualified `trigger`.
- Reports zero, underflow and saturation status.
- Used as a countdown or timeout element beside `upcntr` in the FSM lab designs.

Parameters:
- WIDTH, 2, counter width in bits; legal range 2..16.
- RESET_VAL, {WIDTH{1'b1}}, value loaded into `state` on reset (default = all ones, i.e. 3 for WIDTH=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- trigger  input  1  count enable; level-qualified by default.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value taken by `load`.
- wrap_en  input  1  1 = wrap at zero, 0 = saturate at zero.
- state  output  WIDTH  current count, registered.
- zero  output  1  registered; 1 when `state` == 0.
- underflow  output  1  registered one-cycle pulse on wrap from 0 to all-ones.
- saturated  output  1  registered; 1 while the FSM is in SAT.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high.
- Reset values: `state` = RESET_VAL; `zero` = (RESET_VAL==0); `underflow` = 0; `saturated` = 0; FSM = RUN.
- Reset is sampled on the clk edge only; it is not asynchronous.
- Priority per edge: reset > load > trigger.
- FSM states: RUN, SAT.
- RUN, load=1:
  - `state` <= load_val; stay in RUN.
  - `zero` tracks load_val; `underflow` = 0.
- RUN, trigger=1, state!=0: `state` <= state-1 (modulo 2^WIDTH).
- RUN, trigger=1, state==0, wrap_en=1:
  - `state` <= all-ones; `underflow` = 1 for exactly one cycle; stay in RUN.
- RUN, trigger=1, state==0, wrap_en=0:
  - `state` holds 0; go to SAT; `saturated` = 1 from the next cycle.
- RUN, trigger=0: `state` holds.
- SAT:
  - `trigger` is ignored; `state` = 0.
  - Only load or reset exits to RUN.
  - Load exits in one cycle: `state` = load_val and `saturated` = 0 after that edge.
- Latency: every output reflects the edge at which its inputs were sampled (1-cycle register latency).
- `zero` and `state` update on the same edge.
- `wrap_en` is sampled only when state==0 and trigger=1; changing it mid-count has no other effect.
- `underflow` is never 1 in the same cycle as `saturated`.
- load + trigger in the same cycle: load wins; no decrement and no underflow.
- Reset mid-operation (including in SAT) returns every output to its reset value on that edge.

Optional Feature:
- Macro: DNCNTR_TRIG_EDGE_EN.
- Defined:
  - `trigger` is edge-qualified: one decrement per 0->1 transition of `trigger`.
  - Detector register resets to 1, so a `trigger` held high through reset release does not count.
  - Adds one cycle of latency from `trigger` to `state`.
- Undefined: level mode; one decrement per clock while `trigger` = 1; no detector register.

Decomposition:
- Package dncntr_pkg holds:
  - the FSM state encoding (RUN=1'b0, SAT=1'b1);
  - a localparam function for the all-ones value.
- Sub-module trig_edge_det: 1-bit rising-edge detector with synchronous reset.
  - Instantiated only under DNCNTR_TRIG_EDGE_EN.
  - Reusable by `upcntr`.

Test Plan:
1. Basic count: WIDTH=2, reset for 1 cycle, then trigger=1 held, wrap_en=1 -> `state` 3,2,1,0,3; `underflow`=1 only in the cycle `state` = 3 after 0; `zero`=1 only when `state`=0.
2. Saturate: wrap_en=0, trigger=1 held from `state`=1 -> `state` 0, `saturated`=1 the next cycle, `state` stays 0 for 5 more triggers with `underflow` never asserted.
3. Load priority: load=1, load_val=2, trigger=1 in the same cycle at `state`=0 -> `state`=2, `underflow`=0, `saturated`=0 the next cycle.
4. Exit SAT: in SAT, assert load with load_val=1 -> RUN; one trigger gives `state` 0, `zero`=1.
5. Mid-op reset: assert reset at `state`=1 while trigger=1 -> next cycle `state`=3, all flags 0, FSM=RUN.
6. Edge mode (DNCNTR_TRIG_EDGE_EN defined): trigger held high for 4 cycles -> exactly one decrement; three 1-cycle pulses spaced by 2 cycles -> `state` 3 to 0.
